// File: rtl/axil_read_guard.sv
// ---------------------------------------------------------------------------
// axil_read_guard
//
// Single-outstanding AXI-Lite read stage placed in front of an AXI-Lite slave.
// One read at a time walks IDLE -> ADDR -> WAIT -> RESP. Every handshake
// output is a flop loaded from the next state, so there is no combinational
// path from any input to any output.
//
// Optional feature (macro AXIL_RD_TIMEOUT_EN): a response timeout in WAIT.
// When the downstream slave stays silent for TIMEOUT cycles, the stage answers
// upstream with SLVERR and zero data. It then marks the late downstream
// response as an orphan, which is accepted and discarded whenever it arrives.
// Without the macro, WAIT lasts until the slave responds and no counter or
// orphan logic is built.
//
// Ports
//   clk, rst                   clock (rising edge), async active-high reset
//   s_araddr/s_arvalid/s_arready   upstream read address channel
//   s_rdata/s_rresp/s_rvalid/s_rready  upstream read data channel
//   m_araddr/m_arvalid/m_arready   downstream read address channel
//   m_rdata/m_rresp/m_rvalid/m_rready  downstream read data channel
//   busy                       a read is in flight (state != IDLE)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A source holds valid and its payload stable until that edge. This
// block never withdraws m_arvalid or s_rvalid before its transfer completes.
// ---------------------------------------------------------------------------
module axil_read_guard #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;

    // Handshake outputs, registered from next state.
    logic s_arready_q, m_arvalid_q, m_rready_q, s_rvalid_q;
    logic m_rready_d;

`ifdef AXIL_RD_TIMEOUT_EN
    localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             orphan_q, orphan_d;
    logic             orphan_take;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;
`ifdef AXIL_RD_TIMEOUT_EN
        cnt_d       = cnt_q;
        // A pending orphan owns the next downstream response, even in WAIT.
        orphan_take = orphan_q && m_rvalid && m_rready_q;
        orphan_d    = orphan_q && !orphan_take;
`endif
        case (state_q)
            ST_IDLE: begin
                if (s_arvalid && s_arready_q) begin
                    addr_d  = s_araddr;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // No timeout here: the address stays offered until taken.
                if (m_arvalid_q && m_arready) begin
                    state_d = ST_WAIT;
`ifdef AXIL_RD_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_WAIT: begin
`ifdef AXIL_RD_TIMEOUT_EN
                // A real response wins over a timeout in the same cycle.
                if (m_rvalid && m_rready_q && !orphan_take) begin
                    rdata_d = m_rdata;
                    rresp_d = m_rresp;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d  = '0;
                    rresp_d  = 2'b10;
                    orphan_d = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`else
                if (m_rvalid && m_rready_q) begin
                    rdata_d = m_rdata;
                    rresp_d = m_rresp;
                    state_d = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                if (s_rvalid_q && s_rready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef AXIL_RD_TIMEOUT_EN
        m_rready_d = (state_d == ST_WAIT) || orphan_d;
`else
        m_rready_d = (state_d == ST_WAIT);
`endif
    end

    // Handshake flops reset to 0, so s_arready first rises one edge after
    // reset is released even though the state is already IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rdata_q     <= '0;
            rresp_q     <= '0;
            s_arready_q <= 1'b0;
            m_arvalid_q <= 1'b0;
            m_rready_q  <= 1'b0;
            s_rvalid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            s_arready_q <= (state_d == ST_IDLE);
            m_arvalid_q <= (state_d == ST_ADDR);
            m_rready_q  <= m_rready_d;
            s_rvalid_q  <= (state_d == ST_RESP);
        end
    end

`ifdef AXIL_RD_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            orphan_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            orphan_q <= orphan_d;
        end
    end
`endif

    assign s_arready = s_arready_q;
    assign m_arvalid = m_arvalid_q;
    assign m_rready  = m_rready_q;
    assign s_rvalid  = s_rvalid_q;
    assign m_araddr  = addr_q;
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
